// File: rtl/sdram_pkg.sv
// Constants and types shared by the line cache and the SDRAM burst controller.
// Latency: none; declarations only.
// Backpressure: not applicable.
package sdram_pkg;

    localparam int          LINE_HW    = 32;
    localparam int          RD_SKIP    = 1;
    localparam logic [7:0]  BURST_CODE = 8'(LINE_HW - 1);
    localparam logic [5:0]  LINE_BEATS = 6'(LINE_HW);

    // Controller rw encoding
    localparam logic        CMD_WRITE  = 1'b1;
    localparam logic        CMD_READ   = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB_REQ,
        ST_WB_DATA,
        ST_FILL_REQ,
        ST_FILL_DATA,
        ST_RESP
    } lc_state_t;

    // Replace the bytes of a halfword selected by a 2-bit byte enable
    function automatic logic [15:0] merge_hw(input logic [15:0] old_hw,
                                             input logic [15:0] new_hw,
                                             input logic [1:0]  be);
        logic [15:0] res;
        res = old_hw;
        if (be[0]) res[7:0]  = new_hw[7:0];
        if (be[1]) res[15:8] = new_hw[15:8];
        return res;
    endfunction

endpackage

// File: rtl/sdram_lc_line_ram.sv
// 32x16 line buffer: byte-enabled 32-bit CPU port plus a 16-bit burst beat port.
// Latency: reads are combinational; writes land on the next clock edge.
// Backpressure: none; the beat port takes priority if both ports write at once.
module sdram_lc_line_ram
    import sdram_pkg::*;
(
    input  logic        clk,
    input  logic [3:0]  i_cpu_word,
    input  logic        i_cpu_we,
    input  logic [3:0]  i_cpu_be,
    input  logic [31:0] i_cpu_wdata,
    output logic [31:0] o_cpu_rdata,
    input  logic [4:0]  i_beat_idx,
    input  logic        i_beat_we,
    input  logic [15:0] i_beat_wdata,
    output logic [15:0] o_beat_rdata
);

    logic [15:0] r_hw [LINE_HW];
    logic [4:0]  w_lo_idx;
    logic [4:0]  w_hi_idx;

    assign w_lo_idx = {i_cpu_word, 1'b0};
    assign w_hi_idx = {i_cpu_word, 1'b1};

    // Burst capture or CPU byte merge into the line storage
    always_ff @(posedge clk) begin
        if (i_beat_we) begin
            r_hw[i_beat_idx] <= i_beat_wdata;
        end else if (i_cpu_we) begin
            r_hw[w_lo_idx] <= merge_hw(r_hw[w_lo_idx], i_cpu_wdata[15:0],  i_cpu_be[1:0]);
            r_hw[w_hi_idx] <= merge_hw(r_hw[w_hi_idx], i_cpu_wdata[31:16], i_cpu_be[3:2]);
        end
    end

    assign o_cpu_rdata  = {r_hw[w_hi_idx], r_hw[w_lo_idx]};
    assign o_beat_rdata = r_hw[i_beat_idx];

endmodule

// File: rtl/sdram_line_cache.sv
// Single-line write-back cache turning 32-bit CPU word accesses into 32-halfword SDRAM bursts.
// Latency: hits answer with cpu_ready one cycle after cpu_req; misses add a writeback (if dirty) and a fill burst.
// Backpressure: cpu_req is held until cpu_ready; burst requests are held until the controller starts bursting.
// Optional flush port enabled by defining SDRAM_LC_FLUSH_EN.
module sdram_line_cache
    import sdram_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        mem_ce,
    output logic        mem_rw_req,
    output logic        mem_rw,
    output logic [31:0] mem_address,
    output logic [7:0]  mem_burst_len,
    output logic [15:0] mem_write_data,
    input  logic [15:0] mem_read_data,
    input  logic        mem_data_bursting
`ifdef SDRAM_LC_FLUSH_EN
    ,
    input  logic        flush_req,
    output logic        flush_done
`endif
);

    lc_state_t   r_state, w_next;
    logic        r_valid, r_dirty;
    logic [25:0] r_tag;
    logic [5:0]  r_beat;
    logic [3:0]  r_skip;
    logic        r_req_we;
    logic [31:2] r_req_addr;
    logic [3:0]  r_req_be;
    logic [31:0] r_req_wdata;
    logic        r_cpu_ready;
    logic [31:0] r_cpu_rdata;

    logic        w_cpu_acc, w_hit, w_accept, w_respond;
    logic        w_flush_go, w_wb_to_idle;
    logic        w_wb_cyc, w_fill_cyc, w_capture, w_fill_full, w_wb_end, w_fill_end;
    logic [3:0]  w_ram_word;
    logic        w_ram_cpu_we;
    logic [3:0]  w_ram_be;
    logic [31:0] w_ram_wdata, w_ram_cpu_rdata;
    logic [15:0] w_beat_rdata;
    logic        w_unused_addr_lsb;

    // The ready pulse cycle still shows cpu_req high; ignore it so the access is not repeated
    assign w_cpu_acc    = cpu_req && !r_cpu_ready;
    assign w_hit        = r_valid && (r_tag == cpu_addr[31:6]);
    assign w_accept     = (r_state == ST_IDLE) && w_cpu_acc;
    assign w_respond    = (w_accept && w_hit) || (r_state == ST_RESP);
    assign w_wb_cyc     = ((r_state == ST_WB_REQ) || (r_state == ST_WB_DATA)) && mem_data_bursting;
    assign w_fill_cyc   = ((r_state == ST_FILL_REQ) || (r_state == ST_FILL_DATA)) && mem_data_bursting;
    assign w_capture    = w_fill_cyc && (r_skip == 4'(RD_SKIP)) && (r_beat != LINE_BEATS);
    assign w_fill_full  = (r_beat == LINE_BEATS);
    assign w_wb_end     = (r_state == ST_WB_DATA) && !mem_data_bursting;
    assign w_fill_end   = (r_state == ST_FILL_DATA) && !mem_data_bursting;
    assign w_unused_addr_lsb = &{1'b0, cpu_addr[1:0]};

    // CPU port serves the live request in IDLE and the latched one in RESP
    assign w_ram_word   = (r_state == ST_RESP) ? r_req_addr[5:2] : cpu_addr[5:2];
    assign w_ram_be     = (r_state == ST_RESP) ? r_req_be        : cpu_be;
    assign w_ram_wdata  = (r_state == ST_RESP) ? r_req_wdata     : cpu_wdata;
    assign w_ram_cpu_we = (w_accept && w_hit && cpu_we) || ((r_state == ST_RESP) && r_req_we);

    sdram_lc_line_ram u_line_ram (
        .clk          (clk),
        .i_cpu_word   (w_ram_word),
        .i_cpu_we     (w_ram_cpu_we),
        .i_cpu_be     (w_ram_be),
        .i_cpu_wdata  (w_ram_wdata),
        .o_cpu_rdata  (w_ram_cpu_rdata),
        .i_beat_idx   (r_beat[4:0]),
        .i_beat_we    (w_capture),
        .i_beat_wdata (mem_read_data),
        .o_beat_rdata (w_beat_rdata)
    );

`ifdef SDRAM_LC_FLUSH_EN
    logic r_flushing, r_flush_done;

    // A CPU access in the same cycle wins; flush is taken on a later IDLE cycle
    assign w_flush_go   = flush_req && !r_flush_done && !w_cpu_acc;
    assign w_wb_to_idle = r_flushing;
    assign flush_done   = r_flush_done;

    // Flush bookkeeping: done pulses at once when clean, else after the writeback burst
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_flushing   <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= ((r_state == ST_IDLE) && w_flush_go && !r_dirty) || (w_wb_end && r_flushing);
            if ((r_state == ST_IDLE) && w_flush_go && r_dirty) r_flushing <= 1'b1;
            else if (w_wb_end)                                  r_flushing <= 1'b0;
        end
    end
`else
    assign w_flush_go   = 1'b0;
    assign w_wb_to_idle = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state and controller-facing outputs
    always_comb begin
        w_next         = r_state;
        mem_ce         = 1'b0;
        mem_rw_req     = 1'b0;
        mem_rw         = CMD_READ;
        mem_address    = '0;
        mem_burst_len  = '0;
        mem_write_data = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_cpu_acc) begin
                    if (!w_hit) w_next = r_dirty ? ST_WB_REQ : ST_FILL_REQ;
                end else if (w_flush_go && r_dirty) begin
                    w_next = ST_WB_REQ;
                end
            end
            ST_WB_REQ, ST_WB_DATA: begin
                mem_ce         = 1'b1;
                mem_rw_req     = (r_state == ST_WB_REQ) && !mem_data_bursting;
                mem_rw         = CMD_WRITE;
                mem_address    = {r_tag, 6'b0};
                mem_burst_len  = BURST_CODE;
                mem_write_data = w_beat_rdata;
                if (r_state == ST_WB_REQ && mem_data_bursting) w_next = ST_WB_DATA;
                if (w_wb_end) w_next = w_wb_to_idle ? ST_IDLE : ST_FILL_REQ;
            end
            ST_FILL_REQ, ST_FILL_DATA: begin
                mem_ce         = 1'b1;
                mem_rw_req     = (r_state == ST_FILL_REQ) && !mem_data_bursting;
                mem_address    = {r_req_addr[31:6], 6'b0};
                mem_burst_len  = BURST_CODE;
                if (r_state == ST_FILL_REQ && mem_data_bursting) w_next = ST_FILL_DATA;
                if (w_fill_end) w_next = w_fill_full ? ST_RESP : ST_FILL_REQ;
            end
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Line status, beat/skip counters, request latch and CPU response
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid     <= 1'b0;
            r_dirty     <= 1'b0;
            r_tag       <= '0;
            r_beat      <= '0;
            r_skip      <= '0;
            r_req_we    <= 1'b0;
            r_req_addr  <= '0;
            r_req_be    <= '0;
            r_req_wdata <= '0;
            r_cpu_ready <= 1'b0;
            r_cpu_rdata <= '0;
        end else begin
            r_cpu_ready <= w_respond;
            if (w_respond) r_cpu_rdata <= w_ram_cpu_rdata;
            if (w_accept) begin
                r_req_we    <= cpu_we;
                r_req_addr  <= cpu_addr[31:2];
                r_req_be    <= cpu_be;
                r_req_wdata <= cpu_wdata;
            end
            if (w_ram_cpu_we)  r_dirty <= 1'b1;
            else if (w_wb_end) r_dirty <= 1'b0;
            // Line contents are being replaced, so it is not valid until a full fill lands
            if (r_state == ST_FILL_REQ) begin
                r_valid <= 1'b0;
            end else if (w_fill_end && w_fill_full) begin
                r_valid <= 1'b1;
                r_tag   <= r_req_addr[31:6];
            end
            // Beat saturates at LINE_HW; any idle bus cycle rearms it for the next burst
            if (w_wb_cyc || w_capture) begin
                if (r_beat != LINE_BEATS) r_beat <= r_beat + 6'd1;
            end else if (!mem_data_bursting) begin
                r_beat <= '0;
            end
            if (w_fill_cyc && (r_skip < 4'(RD_SKIP))) r_skip <= r_skip + 4'd1;
            else if (!mem_data_bursting)               r_skip <= '0;
        end
    end

    assign cpu_ready = r_cpu_ready;
    assign cpu_rdata = r_cpu_rdata;

endmodule

// File: tb/tb_sdram_line_cache.sv
`timescale 1ns/1ps
module tb_sdram_line_cache;

    localparam int LHW  = 32;
    localparam int SKIP = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_be;
    logic        cpu_ready;
    logic        mem_ce, mem_rw_req, mem_rw;
    logic [31:0] mem_address;
    logic [7:0]  mem_burst_len;
    logic [15:0] mem_write_data, mem_read_data;
    logic        mem_data_bursting;
`ifdef SDRAM_LC_FLUSH_EN
    logic        flush_req, flush_done;
`endif

    always #5 clk = ~clk;

    sdram_line_cache dut (
        .clk               (clk),
        .reset             (reset),
        .cpu_req           (cpu_req),
        .cpu_we            (cpu_we),
        .cpu_addr          (cpu_addr),
        .cpu_be            (cpu_be),
        .cpu_wdata         (cpu_wdata),
        .cpu_rdata         (cpu_rdata),
        .cpu_ready         (cpu_ready),
        .mem_ce            (mem_ce),
        .mem_rw_req        (mem_rw_req),
        .mem_rw            (mem_rw),
        .mem_address       (mem_address),
        .mem_burst_len     (mem_burst_len),
        .mem_write_data    (mem_write_data),
        .mem_read_data     (mem_read_data),
        .mem_data_bursting (mem_data_bursting)
`ifdef SDRAM_LC_FLUSH_EN
        ,
        .flush_req         (flush_req),
        .flush_done        (flush_done)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // ---------------- behavioural memory models ----------------
    logic [15:0] sdram   [int unsigned];   // SDRAM contents, keyed by halfword address
    logic [31:0] cpu_mem [int unsigned];   // CPU-visible words, keyed by word address

    function automatic logic [15:0] init_hw(input logic [31:0] ba);
        return {ba[13:6], 3'b000, ba[5:1]};
    endfunction

    function automatic logic [15:0] sd_rd(input logic [31:0] ba);
        int unsigned key = ba >> 1;
        if (sdram.exists(key)) return sdram[key];
        return init_hw(ba);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] addr);
        int unsigned key = addr >> 2;
        logic [31:0] a = {addr[31:2], 2'b00};
        if (cpu_mem.exists(key)) return cpu_mem[key];
        return {init_hw(a + 32'd2), init_hw(a)};
    endfunction

    task automatic ref_wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] w = ref_rd(addr);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        cpu_mem[addr >> 2] = w;
    endtask

    // ---------------- burst controller model ----------------
    int          n_rd = 0, n_wr = 0;
    logic [31:0] last_rd_addr = '0, last_wr_addr = '0;
    logic [15:0] last_wb [LHW];
    int          short_fill = 0, extra_beats = 0;

    initial begin : ctrl
        logic        rw;
        logic [31:0] base;
        int          n;
        mem_data_bursting = 1'b0;
        mem_read_data     = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && mem_rw_req === 1'b1) begin
                rw   = mem_rw;
                base = mem_address;
                if (rw) begin
                    n_wr++; last_wr_addr = base; n = LHW;
                end else begin
                    n_rd++; last_rd_addr = base; n = SKIP + LHW + extra_beats;
                    if (short_fill != 0) begin n = SKIP + 10; short_fill = 0; end
                end
                repeat ($urandom_range(2, 0)) @(negedge clk);
                for (int k = 0; k < n; k++) begin
                    mem_data_bursting = 1'b1;
                    if (!rw && k >= SKIP && k < SKIP + LHW)
                        mem_read_data = sd_rd(base + 32'(2 * (k - SKIP)));
                    else
                        mem_read_data = 16'hBAD0;
                    #1;
                    if (reset !== 1'b1) break;
                    if (rw) begin
                        sdram[(base >> 1) + 32'(k)] = mem_write_data;
                        last_wb[k] = mem_write_data;
                    end
                    @(negedge clk);
                end
                mem_data_bursting = 1'b0;
                mem_read_data     = '0;
            end
        end
    end

    // ---------------- CPU access ----------------
    task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, output logic [31:0] rd, output int lat);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wd;
        lat = 0;
        rd  = '0;
        do begin
            @(negedge clk);
            lat++;
        end while (cpu_ready !== 1'b1 && lat < 500);
        if (cpu_ready === 1'b1) begin
            rd = cpu_rdata;
        end else begin
            n_checks++;
            $display("FAIL access_timeout: addr 0x%08h got no cpu_ready within %0d cycles", addr, lat);
        end
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
        if (we) ref_wr(addr, be, wd);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_wr;
        int          exp_rdb;
        logic [31:0] exp_wr_addr;
        logic [31:0] exp_rd_addr;
    } vec_t;

    initial begin : wdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t        vt[5];
        logic [31:0] rd, a;
        int          lat, rd0, wr0, cyc, nb, busy;
        logic        we;

        vt[0] = '{1'b0, 32'h0001_0004, 4'h0, 32'h0,          32'h0003_0002, 0, 1, 32'h0, 32'h0001_0000};
        vt[1] = '{1'b0, 32'h0001_0004, 4'h0, 32'h0,          32'h0003_0002, 0, 0, 32'h0, 32'h0};
        vt[2] = '{1'b1, 32'h0001_0008, 4'b0110, 32'hAABB_CCDD, 32'h0,        0, 0, 32'h0, 32'h0};
        vt[3] = '{1'b0, 32'h0001_0008, 4'h0, 32'h0,          32'h00BB_CC04, 0, 0, 32'h0, 32'h0};
        vt[4] = '{1'b0, 32'h0001_0040, 4'h0, 32'h0,          32'h0101_0100, 1, 1, 32'h0001_0000, 32'h0001_0040};

        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
`ifdef SDRAM_LC_FLUSH_EN
        flush_req = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_ctrl_outputs", {28'h0, cpu_ready, mem_ce, mem_rw_req, mem_rw}, 32'h0);
        check("reset_cpu_rdata", cpu_rdata, 32'h0);
        check("reset_mem_address", mem_address, 32'h0);
        check("reset_len_wdata", {8'h0, mem_burst_len, mem_write_data}, 32'h0);
        busy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_rw_req !== 1'b0) busy++;
        end
        check("idle_no_rw_req", busy, 0);

        // Directed vectors
        for (int i = 0; i < 5; i++) begin
            rd0 = n_rd; wr0 = n_wr;
            cpu_access(vt[i].we, vt[i].addr, vt[i].be, vt[i].wd, rd, lat);
            if (!vt[i].we) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            check($sformatf("vec%0d_wr_bursts", i), n_wr - wr0, vt[i].exp_wr);
            check($sformatf("vec%0d_rd_bursts", i), n_rd - rd0, vt[i].exp_rdb);
            if (vt[i].exp_wr != 0)  check($sformatf("vec%0d_wr_addr", i), last_wr_addr, vt[i].exp_wr_addr);
            if (vt[i].exp_rdb != 0) check($sformatf("vec%0d_rd_addr", i), last_rd_addr, vt[i].exp_rd_addr);
            if (vt[i].exp_wr == 0 && vt[i].exp_rdb == 0) check($sformatf("vec%0d_hit_latency", i), lat, 1);
        end
        check("wb_beat4", {16'h0, last_wb[4]}, 32'h0000_CC04);
        check("wb_beat5", {16'h0, last_wb[5]}, 32'h0000_00BB);

        // Reset during the fill of 0x00020000, at data beat 10
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0002_0000; cpu_be = '0;
        cyc = 0; nb = 0;
        while (nb < SKIP + 11 && cyc < 500) begin
            @(negedge clk); #2;
            if (mem_data_bursting === 1'b1) nb++;
            cyc++;
        end
        if (cyc >= 500) begin n_checks++; $display("FAIL reset_fill_wait: bursts %0d cycles %0d", nb, cyc); end
        reset = 1'b0; cpu_req = 1'b0; cpu_addr = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_abort_outputs", {29'h0, cpu_ready, mem_rw_req, mem_ce}, 32'h0);
        rd0 = n_rd; wr0 = n_wr;
        cpu_access(1'b0, 32'h0002_0000, 4'h0, 32'h0, rd, lat);
        check("refill_rd_bursts", n_rd - rd0, 1);
        check("refill_wr_bursts", n_wr - wr0, 0);
        check("refill_rdata", rd, ref_rd(32'h0002_0000));

        // Truncated fill is retried
        short_fill = 1;
        rd0 = n_rd;
        cpu_access(1'b0, 32'h0003_0010, 4'h0, 32'h0, rd, lat);
        check("short_fill_rd_bursts", n_rd - rd0, 2);
        check("short_fill_rdata", rd, ref_rd(32'h0003_0010));

        // Surplus beats do not wrap into the line
        extra_beats = 3;
        rd0 = n_rd;
        cpu_access(1'b0, 32'h0004_003C, 4'h0, 32'h0, rd, lat);
        extra_beats = 0;
        check("extra_beats_rd_bursts", n_rd - rd0, 1);
        check("extra_beats_rdata_last", rd, ref_rd(32'h0004_003C));
        cpu_access(1'b0, 32'h0004_0000, 4'h0, 32'h0, rd, lat);
        check("extra_beats_rdata_first", rd, ref_rd(32'h0004_0000));
        check("extra_beats_hit_latency", lat, 1);

        // Randomized traffic over a few conflicting lines
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(3, 0))
                0: a = 32'h0005_0000;
                1: a = 32'h0005_0040;
                2: a = 32'h0009_0000;
                default: a = 32'h0005_0080;
            endcase
            a  = a | (32'($urandom_range(15, 0)) << 2);
            we = 1'($urandom_range(1, 0));
            if (we) begin
                cpu_access(1'b1, a, 4'($urandom_range(15, 0)), $urandom, rd, lat);
            end else begin
                cpu_access(1'b0, a, 4'h0, 32'h0, rd, lat);
                check($sformatf("rand%0d_rdata@%08h", i, a), rd, ref_rd(a));
            end
        end
        // Evict whatever is resident, then SDRAM must hold every CPU-visible word
        cpu_access(1'b0, 32'h000A_0000, 4'h0, 32'h0, rd, lat);
        check("evict_rdata", rd, ref_rd(32'h000A_0000));
        foreach (cpu_mem[k]) begin
            a = k << 2;
            check($sformatf("sdram_word@%08h", a), {sd_rd(a + 32'd2), sd_rd(a)}, cpu_mem[k]);
        end

`ifdef SDRAM_LC_FLUSH_EN
        cpu_access(1'b1, 32'h0006_0004, 4'hF, 32'h1234_5678, rd, lat);
        wr0 = n_wr; rd0 = n_rd;
        @(negedge clk);
        flush_req = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (flush_done !== 1'b1 && cyc < 500);
        flush_req = 1'b0;
        check("flush_done_seen", {31'h0, flush_done}, 32'h1);
        check("flush_wr_bursts", n_wr - wr0, 1);
        check("flush_wr_addr", last_wr_addr, 32'h0006_0000);
        check("flush_wb_beat2", {last_wb[3], last_wb[2]}, 32'h1234_5678);
        cpu_access(1'b0, 32'h0006_0004, 4'h0, 32'h0, rd, lat);
        check("post_flush_hit_latency", lat, 1);
        check("post_flush_rdata", rd, 32'h1234_5678);
        check("post_flush_no_bursts", (n_wr - wr0) + (n_rd - rd0), 1);
        wr0 = n_wr;
        @(negedge clk);
        flush_req = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (flush_done !== 1'b1 && cyc < 500);
        flush_req = 1'b0;
        check("clean_flush_latency", cyc, 1);
        check("clean_flush_no_burst", n_wr - wr0, 0);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
